// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring on magnitudes)
// engine producing the HI/LO words for the CPU's HI and LO registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE at a rising edge; done is a
  // one-cycle pulse after which hi_out/lo_out stay stable until the next result.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_ZDIV  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic             op_q;
  logic [WIDTH:0]   acc_a_q;
  logic [WIDTH-1:0] acc_q_q;
  logic             qm1_q;
  logic [WIDTH:0]   m_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   acc_a_d;
  logic [WIDTH-1:0] acc_q_d;
  logic             qm1_d;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Two's-complement magnitudes; 0x80000000 maps to 2^31 as an unsigned value.
  assign mag_a = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
  assign mag_b = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;

  always_comb begin
    booth_sum = acc_a_q;
    rem_shift = {acc_a_q[WIDTH-1:0], acc_q_q[WIDTH-1]};
    trial     = rem_shift - m_q;
    acc_a_d   = acc_a_q;
    acc_q_d   = acc_q_q;
    qm1_d     = qm1_q;
    if (!op_q) begin
      unique case ({acc_q_q[0], qm1_q})
        2'b01:   booth_sum = acc_a_q + m_q;
        2'b10:   booth_sum = acc_a_q - m_q;
        default: booth_sum = acc_a_q;
      endcase
      acc_a_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      acc_q_d = {booth_sum[0], acc_q_q[WIDTH-1:1]};
      qm1_d   = acc_q_q[0];
    end else begin
      // A negative trial keeps the shifted remainder (the restore step).
      acc_a_d = trial[WIDTH] ? {1'b0, rem_shift[WIDTH-1:0]} : {1'b0, trial[WIDTH-1:0]};
      acc_q_d = {acc_q_q[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      op_q       <= 1'b0;
      acc_a_q    <= '0;
      acc_q_q    <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            div_zero_q <= 1'b0;
            if (op && (src_b == '0)) begin
              state_q <= S_ZDIV;
            end else begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              count_q   <= '0;
              op_q      <= op;
              acc_a_q   <= '0;
              qm1_q     <= 1'b0;
              quo_neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
              rem_neg_q <= src_a[WIDTH-1];
              if (!op) begin
                acc_q_q <= src_b;
                m_q     <= {src_a[WIDTH-1], src_a};
              end else begin
                acc_q_q <= mag_a;
                m_q     <= {1'b0, mag_b};
              end
            end
          end
        end
        S_RUN: begin
          acc_a_q <= acc_a_d;
          acc_q_q <= acc_q_d;
          qm1_q   <= qm1_d;
          count_q <= count_q + 1'b1;
          // busy falls with the final iteration so it covers exactly WIDTH cycles.
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIXUP;
            busy_q  <= 1'b0;
          end
        end
        S_FIXUP: begin
          if (!op_q) begin
            hi_q <= acc_a_q[WIDTH-1:0];
            lo_q <= acc_q_q;
          end else begin
            hi_q <= rem_neg_q ? ('0 - acc_a_q[WIDTH-1:0]) : acc_a_q[WIDTH-1:0];
            lo_q <= quo_neg_q ? ('0 - acc_q_q) : acc_q_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ZDIV: begin
          done_q     <= 1'b1;
          div_zero_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign state_dbg = state_q;

endmodule
